// File: rtl/act_feeder.sv
// Activation feeder: host-loaded pair buffer streamed to sblk as one burst of
// n_tn*n_tp*N_TILE packed words per level request.
module act_feeder #(
  parameter int unsigned N_TILE      = 4,
  parameter int unsigned WID_ACT     = 16,
  parameter int unsigned WID_ACTADDR = 6,
  parameter int unsigned WID_INST_TN = 4,
  parameter int unsigned WID_INST_TP = 5
) (
  input  logic                     clk_l,
  input  logic                     rst_n,
  input  logic                     cfg_en,
  input  logic [WID_INST_TN-1:0]   cfg_tn,
  input  logic [WID_INST_TP-1:0]   cfg_tp,
  input  logic                     wr_en,
  input  logic [WID_ACTADDR-1:0]   wr_addr,
  input  logic [2*WID_ACT-1:0]     wr_data,
  input  logic                     act_data_in_req,
  output logic                     act_data_out_vld,
  output logic [2*WID_ACT-1:0]     act_data_out,
  output logic                     busy,
  output logic                     burst_done
);

  localparam int unsigned WID_DATA = 2 * WID_ACT;
  localparam int unsigned LOG2_NT  = $clog2(N_TILE);
  localparam int unsigned WID_LEN  = WID_INST_TN + WID_INST_TP + LOG2_NT;
  localparam int unsigned DEPTH    = 1 << WID_ACTADDR;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WID_LEN-1:0]       cnt_q, cnt_d;
  logic [WID_INST_TN-1:0]   tn_q;
  logic [WID_INST_TP-1:0]   tp_q;
  logic [WID_ACTADDR-1:0]   rd_ptr_q;
  logic                     rd_vld_q, last1_q, last2_q;
  logic [WID_DATA-1:0]      rd_q;
  logic [WID_DATA-1:0]      mem [DEPTH];

  logic                     cfg_take_c;
  logic [WID_INST_TN-1:0]   tn_sel_c;
  logic [WID_INST_TP-1:0]   tp_sel_c;
  logic [WID_LEN-1:0]       len_c;
  logic                     rd_en_c;
  logic                     last_c;
  logic                     pipe_empty_c;

  // A config arriving with the request is used for that same burst.
  assign cfg_take_c   = cfg_en && (state_q == S_IDLE);
  assign tn_sel_c     = cfg_take_c ? cfg_tn : tn_q;
  assign tp_sel_c     = cfg_take_c ? cfg_tp : tp_q;
  assign len_c        = (WID_LEN'(tn_sel_c) * WID_LEN'(tp_sel_c)) << LOG2_NT;
  assign pipe_empty_c = !rd_vld_q && !act_data_out_vld && !last1_q && !last2_q;

  // Next-state and read-issue logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en_c = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (act_data_in_req) begin
          if (len_c != '0) begin
            state_d = S_STREAM;
            cnt_d   = len_c;
          end else begin
            // Zero-length burst still reports completion through the done pipe.
            state_d = S_WAIT_LOW;
            last_c  = 1'b1;
          end
        end
      end
      S_STREAM: begin
        rd_en_c = 1'b1;
        cnt_d   = cnt_q - WID_LEN'(1);
        if (cnt_q == WID_LEN'(1)) begin
          last_c  = 1'b1;
          state_d = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!act_data_in_req && pipe_empty_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, config, pointer and output pipeline.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      tn_q             <= '0;
      tp_q             <= '0;
      rd_ptr_q         <= '0;
      rd_vld_q         <= 1'b0;
      last1_q          <= 1'b0;
      last2_q          <= 1'b0;
      act_data_out_vld <= 1'b0;
      act_data_out     <= '0;
      busy             <= 1'b0;
      burst_done       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_take_c) begin
        tn_q <= cfg_tn;
        tp_q <= cfg_tp;
      end
      if (cfg_take_c)   rd_ptr_q <= '0;
      else if (rd_en_c) rd_ptr_q <= rd_ptr_q + WID_ACTADDR'(1);
      rd_vld_q         <= rd_en_c;
      last1_q          <= last_c;
      last2_q          <= last1_q;
      burst_done       <= last2_q;
      act_data_out_vld <= rd_vld_q;
      act_data_out     <= rd_vld_q ? rd_q : '0;
      busy             <= (state_d != S_IDLE);
    end
  end

  // Buffer RAM: contents are not reset; same-address read returns old data.
  always_ff @(posedge clk_l) begin
    if (wr_en)   mem[wr_addr] <= wr_data;
    if (rd_en_c) rd_q <= mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_act_feeder.sv
// Directed bench for act_feeder: table of bursts plus a reset-abort sequence.
module tb_act_feeder;

  logic        clk_l;
  logic        rst_n;
  logic        cfg_en;
  logic [3:0]  cfg_tn;
  logic [4:0]  cfg_tp;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        act_data_in_req;
  logic        act_data_out_vld;
  logic [31:0] act_data_out;
  logic        busy;
  logic        burst_done;

  int n_cmp = 0;
  int n_bad = 0;

  act_feeder dut (
    .clk_l            (clk_l),
    .rst_n            (rst_n),
    .cfg_en           (cfg_en),
    .cfg_tn           (cfg_tn),
    .cfg_tp           (cfg_tp),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .act_data_in_req  (act_data_in_req),
    .act_data_out_vld (act_data_out_vld),
    .act_data_out     (act_data_out),
    .busy             (busy),
    .burst_done       (burst_done)
  );

  initial clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  // mode: 0 = keep config, 1 = cfg cycle before req, 2 = cfg with req
  typedef struct {
    int mode;
    int tn;
    int tp;
    int start;
    int len;
    bit hold;
    bit mid_cfg;
  } vec_t;

  vec_t tbl[13];

  task automatic cyc();
    @(posedge clk_l);
    #1;
  endtask

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    int m;
    m = a % 64;
    return {16'(2 * m + 1), 16'(2 * m)};
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int first_vld, last_vld, nbeats, done_k, ndone, bad_idle, busy_drop, limit;
    first_vld = -1; last_vld = -1; nbeats = 0; done_k = -1;
    ndone = 0; bad_idle = 0; busy_drop = 0;
    if (v.mode == 1) begin
      cfg_en = 1'b1; cfg_tn = 4'(v.tn); cfg_tp = 5'(v.tp);
      cyc();
      cfg_en = 1'b0;
    end else if (v.mode == 2) begin
      cfg_en = 1'b1; cfg_tn = 4'(v.tn); cfg_tp = 5'(v.tp);
    end
    act_data_in_req = 1'b1;
    cyc();
    cfg_en = 1'b0;
    chk({nm, "_busy_rise"}, longint'(busy), 1);
    limit = v.hold ? 100 : v.len + 8;
    for (int k = 1; k <= limit; k++) begin
      if (v.mid_cfg && k == 5) begin
        cfg_en = 1'b1; cfg_tn = 4'd1;
      end
      cyc();
      cfg_en = 1'b0;
      if (act_data_out_vld) begin
        if (first_vld < 0) first_vld = k;
        chk({nm, "_data"}, longint'(act_data_out), longint'(exp_word(v.start + nbeats)));
        nbeats++;
        last_vld = k;
      end else if (act_data_out != 32'd0) begin
        bad_idle++;
      end
      if (burst_done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (v.hold && !busy) busy_drop++;
      if (!v.hold && k == 2) act_data_in_req = 1'b0;
    end
    chk({nm, "_first_vld"}, first_vld, (v.len > 0) ? 2 : -1);
    chk({nm, "_last_vld"}, last_vld, (v.len > 0) ? v.len + 1 : -1);
    chk({nm, "_beats"}, nbeats, v.len);
    chk({nm, "_done_cycle"}, done_k, v.len + 2);
    chk({nm, "_done_pulses"}, ndone, 1);
    chk({nm, "_data_zero_idle"}, bad_idle, 0);
    if (v.hold) begin
      chk({nm, "_busy_held"}, busy_drop, 0);
      act_data_in_req = 1'b0;
      cyc();
      chk({nm, "_busy_fall"}, longint'(busy), 0);
    end else begin
      chk({nm, "_idle_after"}, longint'(busy), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb;
    vec_t v;
    tbl[0]  = '{1, 2, 2, 0, 16, 1'b0, 1'b0};    // basic burst
    tbl[1]  = '{1, 2, 3, 0, 24, 1'b0, 1'b0};    // continuation
    tbl[2]  = '{0, 0, 0, 24, 24, 1'b0, 1'b0};
    tbl[3]  = '{0, 0, 0, 48, 24, 1'b0, 1'b0};   // wraps 63 -> 0
    tbl[4]  = '{1, 0, 5, 0, 0, 1'b0, 1'b0};     // zero length
    tbl[5]  = '{1, 2, 2, 0, 16, 1'b1, 1'b0};    // held request
    tbl[6]  = '{0, 0, 0, 16, 16, 1'b0, 1'b0};
    tbl[7]  = '{1, 2, 2, 0, 16, 1'b0, 1'b1};    // cfg while busy
    tbl[8]  = '{0, 0, 0, 16, 16, 1'b0, 1'b0};
    tbl[9]  = '{2, 1, 1, 0, 4, 1'b0, 1'b0};     // cfg with req
    tbl[10] = '{2, 15, 1, 0, 60, 1'b0, 1'b0};
    tbl[11] = '{0, 0, 0, 60, 60, 1'b0, 1'b0};
    tbl[12] = '{1, 15, 31, 0, 1860, 1'b0, 1'b0}; // full-width length

    rst_n = 1'b0; cfg_en = 1'b0; cfg_tn = '0; cfg_tp = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; act_data_in_req = 1'b0;
    repeat (3) cyc();
    chk("rst_vld", longint'(act_data_out_vld), 0);
    chk("rst_data", longint'(act_data_out), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(burst_done), 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = exp_word(i);
      cyc();
    end
    wr_en = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted on the fifth beat of a burst.
    cfg_en = 1'b1; cfg_tn = 4'd2; cfg_tp = 5'd2;
    cyc();
    cfg_en = 1'b0;
    act_data_in_req = 1'b1;
    cyc();
    nb = 0;
    for (int k = 0; k < 20 && nb < 5; k++) begin
      cyc();
      if (act_data_out_vld) nb++;
    end
    chk("rstmid_reach_beat5", nb, 5);
    rst_n = 1'b0;
    act_data_in_req = 1'b0;
    #1;
    chk("rstmid_vld", longint'(act_data_out_vld), 0);
    chk("rstmid_data", longint'(act_data_out), 0);
    chk("rstmid_busy", longint'(busy), 0);
    #2;
    rst_n = 1'b1;
    cyc();
    chk("rstmid_idle", longint'(busy), 0);
    v = '{0, 0, 0, 0, 0, 1'b0, 1'b0};           // counts cleared: L = 0
    run_vec(v, "rstmid_zero");
    v = '{1, 2, 2, 0, 16, 1'b0, 1'b0};
    run_vec(v, "rstmid_recfg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
